// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode, error code and FSM state definitions for the sequential ALU
package seq_alu_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_ILL    = 4'h1;
   localparam logic [3:0] OP_ADD    = 4'h2;
   localparam logic [3:0] OP_SUB    = 4'h3;
   localparam logic [3:0] OP_MUL    = 4'h4;
   localparam logic [3:0] OP_DIV    = 4'h5;
   localparam logic [3:0] OP_MOD    = 4'h6;
   localparam logic [3:0] OP_OR     = 4'h7;
   localparam logic [3:0] OP_AND    = 4'h8;
   localparam logic [3:0] OP_XOR    = 4'h9;
   localparam logic [3:0] OP_NAND   = 4'hA;
   localparam logic [3:0] OP_NOR    = 4'hB;
   localparam logic [3:0] OP_XNOR   = 4'hC;
   localparam logic [3:0] OP_NOT    = 4'hD;
   localparam logic [3:0] OP_PRESET = 4'hE;
   localparam logic [3:0] OP_RESET  = 4'hF;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_UNDER   = 2'b01;
   localparam logic [1:0] ERR_DIVZ    = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - iterative shift-add multiplier and restoring divider, one bit per cycle
module seq_muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               mode_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o,
   output logic [WIDTH-1:0]   quotient_o,
   output logic [WIDTH-1:0]   remainder_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic               run_q;
   logic               div_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dvsr_q;

   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH:0]     trial;
   logic               restore;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;

   always_comb begin
      prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
      trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
      restore = trial[WIDTH];
      // The partial remainder is always below the divisor, so its MSB is zero when restoring.
      rem_d   = restore ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ~restore};
   end

   // Results are the next-state values so the owner can capture them on the final iteration edge.
   assign done_o      = run_q && (cnt_q == CW'(WIDTH - 1));
   assign product_o   = prod_d;
   assign quotient_o  = quo_d;
   assign remainder_o = rem_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         run_q    <= 1'b0;
         div_q    <= 1'b0;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
      end else if (start_i) begin
         run_q    <= 1'b1;
         div_q    <= mode_div_i;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         rem_q    <= '0;
         quo_q    <= a_i;
         dvsr_q   <= b_i;
      end else if (run_q) begin
         cnt_q <= cnt_q + CW'(1);
         if (div_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
         end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
         end
         if (done_o) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu_accumulator.sv
// rtl/seq_alu_accumulator.sv - accumulator ALU with valid/ready input and iterative MUL/DIV/MOD
module seq_alu_accumulator
   import seq_alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit ERR_STICKY = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [3:0]         op_i,
   input  logic [WIDTH-1:0]   in_i,
   output logic [2*WIDTH-1:0] out_o,
   output logic               done_o,
   output logic               busy_o,
   output logic [1:0]         err_o
);

   localparam int AW = 2 * WIDTH;

   function automatic logic [AW-1:0] zext(input logic [WIDTH-1:0] x);
      return {{WIDTH{1'b0}}, x};
   endfunction

   state_t          state_q;
   logic [AW-1:0]   acc_q;
   logic [1:0]      err_q;
   logic            done_q;
   logic            busy_q;
   logic            ready_q;
   logic            rem_sel_q;

   logic [WIDTH-1:0] a;
   logic             accept;
   logic             is_mul;
   logic             is_div;
   logic             start;
   logic [AW-1:0]    sc_acc;
   logic [1:0]       sc_err;
   logic [1:0]       sc_err_next;
   logic [1:0]       md_err_next;

   logic             md_done;
   logic [AW-1:0]    md_product;
   logic [WIDTH-1:0] md_quotient;
   logic [WIDTH-1:0] md_remainder;

   assign a      = acc_q[WIDTH-1:0];
   assign accept = in_valid_i & ready_q;
   assign is_mul = (op_i == OP_MUL);
   assign is_div = (op_i == OP_DIV) || (op_i == OP_MOD);
   // Divide by zero stays a single-cycle op and never launches the iterative core.
   assign start  = accept & (is_mul | (is_div & (in_i != '0)));

   always_comb begin
      sc_acc = acc_q;
      sc_err = ERR_NONE;
      case (op_i)
         OP_ILL:  sc_err = ERR_ILLEGAL;
         OP_ADD:  sc_acc = zext(a) + zext(in_i);
         OP_SUB: begin
            sc_acc = zext(a) - zext(in_i);
            if (a < in_i) sc_err = ERR_UNDER;
         end
         OP_DIV, OP_MOD: begin
            sc_acc = '0;
            sc_err = ERR_DIVZ;
         end
         OP_OR:     sc_acc = zext(a | in_i);
         OP_AND:    sc_acc = zext(a & in_i);
         OP_XOR:    sc_acc = zext(a ^ in_i);
         OP_NAND:   sc_acc = zext(~(a & in_i));
         OP_NOR:    sc_acc = zext(~(a | in_i));
         OP_XNOR:   sc_acc = zext(~(a ^ in_i));
         OP_NOT:    sc_acc = zext(~a);
         OP_PRESET: sc_acc = '1;
         OP_RESET:  sc_acc = '0;
         default:   sc_acc = acc_q;
      endcase
   end

   assign sc_err_next = ERR_STICKY ? ((op_i == OP_RESET) ? ERR_NONE : (err_q | sc_err)) : sc_err;
   assign md_err_next = ERR_STICKY ? err_q : ERR_NONE;

   seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start),
      .mode_div_i  (is_div),
      .a_i         (a),
      .b_i         (in_i),
      .done_o      (md_done),
      .product_o   (md_product),
      .quotient_o  (md_quotient),
      .remainder_o (md_remainder)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         err_q     <= ERR_NONE;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         rem_sel_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q   <= is_mul ? ST_MUL : ST_DIV;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                  rem_sel_q <= (op_i == OP_MOD);
               end else if (accept) begin
                  acc_q  <= sc_acc;
                  err_q  <= sc_err_next;
                  done_q <= 1'b1;
               end
            end
            ST_MUL, ST_DIV: begin
               if (md_done) begin
                  if (state_q == ST_MUL) acc_q <= md_product;
                  else acc_q <= rem_sel_q ? zext(md_remainder) : zext(md_quotient);
                  err_q   <= md_err_next;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o = ready_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign out_o      = acc_q;

endmodule
